// File: rtl/sram_access_scheduler_if.sv
// Requester and SRAM pin bundle for the SRAM access scheduler.
interface sram_access_scheduler_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 8
);
  // display read stream
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  // record write stream
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  // SRAM pins (dq tristate lives in top)
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_cs_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;

  // scheduler side
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, sram_dq_in,
    output rd_ready, rd_data, rd_valid, wr_ready,
    output sram_addr, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
  );

  // requester / pad side
  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, sram_dq_in,
    input  rd_ready, rd_data, rd_valid, wr_ready,
    input  sram_addr, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_access_scheduler.sv
// Shares one async SRAM between the display read stream and a FIFO-buffered
// record write stream; sequences OE/WE so WE only pulses with stable addr/data.
module sram_access_scheduler #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                     rpi_pixel_clock,
  input  logic                     rst,
  sram_access_scheduler_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // write FIFO
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_push;
  logic              w_pop;

  // arbitration
  logic [STV_W-1:0]  r_starve;
  logic [STV_W-1:0]  w_starve_nxt;
  logic              w_rd_grant;
  logic              w_wr_grant;
  logic              w_fifo_empty;

  // registered outputs and their next values
  logic [ADDR_W-1:0] r_sram_addr,   w_sram_addr_nxt;
  logic              r_sram_cs_n;
  logic              r_sram_oe_n,   w_sram_oe_n_nxt;
  logic              r_sram_we_n,   w_sram_we_n_nxt;
  logic [DATA_W-1:0] r_sram_dq_out, w_sram_dq_out_nxt;
  logic              r_sram_dq_oe,  w_sram_dq_oe_nxt;
  logic [DATA_W-1:0] r_rd_data,     w_rd_data_nxt;
  logic              r_rd_valid,    w_rd_valid_nxt;
  logic              r_rd_ready,    w_rd_ready_nxt;
  logic              r_wr_ready,    w_wr_ready_nxt;

  assign w_fifo_empty = (r_count == CNT_W'(0));
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_data  = r_fifo_data[r_rd_ptr];

  // Grants: a read wins in IDLE unless starvation has dropped rd_ready
  assign w_rd_grant = (r_state == ST_IDLE) && bus.rd_req && r_rd_ready;
  assign w_wr_grant = (r_state == ST_IDLE) && !w_rd_grant && !w_fifo_empty;

  assign w_push      = bus.wr_valid && r_wr_ready;
  assign w_pop       = w_wr_grant;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Starvation count: reads that bypassed a waiting write since the last write grant
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_wr_grant || w_fifo_empty) begin
      w_starve_nxt = '0;
    end else if (w_rd_grant && (r_starve < STV_W'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge rpi_pixel_clock) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rd_grant) begin
          w_state_nxt = ST_RD_WAIT;
        end else if (w_wr_grant) begin
          w_state_nxt = ST_WR_SETUP;
        end
      end
      ST_RD_WAIT:  w_state_nxt = ST_IDLE;
      ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: w_state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the pins and response registers
  always_comb begin
    w_sram_addr_nxt   = r_sram_addr;
    w_sram_oe_n_nxt   = r_sram_oe_n;
    w_sram_we_n_nxt   = r_sram_we_n;
    w_sram_dq_out_nxt = r_sram_dq_out;
    w_sram_dq_oe_nxt  = r_sram_dq_oe;
    w_rd_data_nxt     = r_rd_data;
    w_rd_valid_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rd_grant) begin
          w_sram_addr_nxt = bus.rd_addr;
          w_sram_oe_n_nxt = 1'b0;
        end else if (w_wr_grant) begin
          w_sram_addr_nxt   = w_head_addr;
          w_sram_dq_out_nxt = w_head_data;
          w_sram_dq_oe_nxt  = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        w_rd_data_nxt   = bus.sram_dq_in;
        w_rd_valid_nxt  = 1'b1;
        w_sram_oe_n_nxt = 1'b1;
      end
      ST_WR_SETUP: w_sram_we_n_nxt  = 1'b0;
      ST_WR_PULSE: w_sram_we_n_nxt  = 1'b1;
      ST_WR_HOLD:  w_sram_dq_oe_nxt = 1'b0;
      default: begin
        w_sram_oe_n_nxt  = 1'b1;
        w_sram_we_n_nxt  = 1'b1;
        w_sram_dq_oe_nxt = 1'b0;
      end
    endcase
    w_rd_ready_nxt = (w_state_nxt == ST_IDLE) && (w_starve_nxt < STV_W'(STARVE_LIMIT));
    w_wr_ready_nxt = (w_count_nxt != CNT_W'(FIFO_DEPTH));
  end

  // Output registers; cs_n drops on the first edge after reset and stays low
  always_ff @(posedge rpi_pixel_clock) begin
    if (rst) begin
      r_sram_addr   <= '0;
      r_sram_cs_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
      r_sram_we_n   <= 1'b1;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_ready    <= 1'b0;
      r_wr_ready    <= 1'b0;
    end else begin
      r_sram_addr   <= w_sram_addr_nxt;
      r_sram_cs_n   <= 1'b0;
      r_sram_oe_n   <= w_sram_oe_n_nxt;
      r_sram_we_n   <= w_sram_we_n_nxt;
      r_sram_dq_out <= w_sram_dq_out_nxt;
      r_sram_dq_oe  <= w_sram_dq_oe_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_rd_valid    <= w_rd_valid_nxt;
      r_rd_ready    <= w_rd_ready_nxt;
      r_wr_ready    <= w_wr_ready_nxt;
    end
  end

  // FIFO pointers, occupancy and starvation count; reset discards contents
  always_ff @(posedge rpi_pixel_clock) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // FIFO storage
  always_ff @(posedge rpi_pixel_clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.wr_addr;
      r_fifo_data[r_wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_cs_n   = r_sram_cs_n;
  assign bus.sram_oe_n   = r_sram_oe_n;
  assign bus.sram_we_n   = r_sram_we_n;
  assign bus.sram_dq_out = r_sram_dq_out;
  assign bus.sram_dq_oe  = r_sram_dq_oe;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_ready    = r_rd_ready;
  assign bus.wr_ready    = r_wr_ready;

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Scoreboard bench for sram_access_scheduler with a behavioural SRAM.
module tb_sram_access_scheduler;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_access_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_access_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .STARVE_LIMIT(16)
  ) dut (
    .rpi_pixel_clock(clk),
    .rst(rst),
    .bus(bus)
  );

  // Read region (addr < 0x20000) holds a fixed pattern; writes go to the upper half.
  function automatic logic [7:0] rd_pattern(input logic [17:0] a);
    if (a == 18'h00123) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {6'h00, a[17:16]} ^ 8'h3C;
  endfunction

  assign bus.sram_dq_in = (!bus.sram_oe_n && !bus.sram_cs_n) ? rd_pattern(bus.sram_addr) : 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int we_falls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] data; int unsigned due; } rd_exp_t;
  typedef struct { logic [17:0] addr; logic [7:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  // Issue tracker: every accepted request pushes its expected response
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.rd_req && bus.rd_ready) rd_q.push_back('{rd_pattern(bus.rd_addr), cyc + 2});
      if (bus.wr_valid && bus.wr_ready) wr_q.push_back('{bus.wr_addr, bus.wr_data});
    end
  end

  // Read response monitor
  initial forever begin
    rd_exp_t e;
    @(negedge clk);
    if (!rst && bus.rd_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_valid_spurious", 32'(bus.rd_valid), 32'(0));
      end else begin
        e = rd_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e.data));
        check("rd_latency", cyc, e.due);
      end
    end
  end

  // SRAM pin monitor: WE pulse shape, addr/data stability, OE/dq_oe exclusion
  initial begin
    logic p_we_n, p_dq_oe;
    logic [17:0] p_addr;
    logic [7:0]  p_dout;
    int plen;
    wr_exp_t e;
    p_we_n = 1'b1; p_dq_oe = 1'b0; p_addr = '0; p_dout = '0; plen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_we_n = 1'b1; p_dq_oe = 1'b0; plen = 0;
      end else begin
        check("oe_dqoe_exclusive", 32'(!bus.sram_oe_n && bus.sram_dq_oe), 32'(0));
        if (!bus.sram_we_n) begin
          if (p_we_n) begin
            we_falls++;
            check("we_setup_dq_oe", 32'(p_dq_oe), 32'(1));
            check("we_setup_addr", 32'(p_addr), 32'(bus.sram_addr));
            check("we_setup_data", 32'(p_dout), 32'(bus.sram_dq_out));
          end
          plen++;
          check("we_low_oe_n", 32'(bus.sram_oe_n), 32'(1));
          check("we_low_dq_oe", 32'(bus.sram_dq_oe), 32'(1));
        end else if (!p_we_n) begin
          check("we_pulse_len", 32'(plen), 32'(1));
          check("we_hold_dq_oe", 32'(bus.sram_dq_oe), 32'(1));
          check("we_hold_addr", 32'(bus.sram_addr), 32'(p_addr));
          check("we_hold_data", 32'(bus.sram_dq_out), 32'(p_dout));
          if (wr_q.size() == 0) begin
            check("wr_spurious", 32'(wr_q.size()), 32'(1));
          end else begin
            e = wr_q.pop_front();
            check("wr_addr_order", 32'(p_addr), 32'(e.addr));
            check("wr_data_order", 32'(p_dout), 32'(e.data));
          end
          plen = 0;
        end
        p_we_n  = bus.sram_we_n;
        p_dq_oe = bus.sram_dq_oe;
        p_addr  = bus.sram_addr;
        p_dout  = bus.sram_dq_out;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
    $fatal(1, "watchdog");
  end

  // Driver state sampled just before each active edge
  logic rd_acc, wr_acc, dq_oe_s;

  task automatic step();
    @(negedge clk);
    rd_acc  = bus.rd_req && bus.rd_ready;
    wr_acc  = bus.wr_valid && bus.wr_ready;
    dq_oe_s = bus.sram_dq_oe;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] rnd_rd_addr();
    return 18'($urandom_range(0, 32'h1FFFF));
  endfunction

  function automatic logic [17:0] rnd_wr_addr();
    return 18'h20000 | 18'($urandom_range(0, 32'h1FFFF));
  endfunction

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rd_q.size() == 0 && wr_q.size() == 0 && !bus.sram_dq_oe && bus.sram_we_n &&
          bus.sram_oe_n && !bus.rd_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("drain_done", 32'(done), 32'(1));
  endtask

  task automatic release_rd();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_acc) begin
        done = 1'b1;
        break;
      end
    end
    bus.rd_req = 1'b0;
    check("rd_release", 32'(done), 32'(1));
  endtask

  initial begin
    int n_acc, nrd, base;
    logic seen;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rd_acc = 1'b0; wr_acc = 1'b0; dq_oe_s = 1'b0;

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",   32'(bus.sram_cs_n),   32'(1));
    check("rst_oe_n",   32'(bus.sram_oe_n),   32'(1));
    check("rst_we_n",   32'(bus.sram_we_n),   32'(1));
    check("rst_dq_oe",  32'(bus.sram_dq_oe),  32'(0));
    check("rst_addr",   32'(bus.sram_addr),   32'(0));
    check("rst_dq_out", 32'(bus.sram_dq_out), 32'(0));
    check("rst_rd_data",  32'(bus.rd_data),  32'(0));
    check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("rst_rd_ready", 32'(bus.rd_ready), 32'(0));
    check("rst_wr_ready", 32'(bus.wr_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("cs_n_after_release", 32'(bus.sram_cs_n), 32'(0));
    check("rd_ready_after_release", 32'(bus.rd_ready), 32'(1));
    check("wr_ready_after_release", 32'(bus.wr_ready), 32'(1));

    // directed read of 0x00123 (pattern 0xA5)
    bus.rd_req = 1'b1; bus.rd_addr = 18'h00123;
    step();
    check("rd_accept", 32'(rd_acc), 32'(1));
    bus.rd_req = 1'b0;
    check("rd_oe_n_low", 32'(bus.sram_oe_n), 32'(0));
    check("rd_addr_pins", 32'(bus.sram_addr), 32'h00123);
    step();
    check("rd_oe_n_released", 32'(bus.sram_oe_n), 32'(1));
    check("rd_valid_pulse", 32'(bus.rd_valid), 32'(1));
    step();
    check("rd_valid_one_cycle", 32'(bus.rd_valid), 32'(0));

    // directed write at the top address
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h3FFFF; bus.wr_data = 8'h5A;
    step();
    check("wr_accept", 32'(wr_acc), 32'(1));
    bus.wr_valid = 1'b0;
    step();
    check("wr_setup_dq_oe", 32'(bus.sram_dq_oe), 32'(1));
    check("wr_setup_addr", 32'(bus.sram_addr), 32'h3FFFF);
    check("wr_setup_data", 32'(bus.sram_dq_out), 32'h5A);
    check("wr_setup_we_n", 32'(bus.sram_we_n), 32'(1));
    step();
    check("wr_pulse_we_n", 32'(bus.sram_we_n), 32'(0));
    step();
    check("wr_hold_we_n", 32'(bus.sram_we_n), 32'(1));
    check("wr_hold_dq_oe", 32'(bus.sram_dq_oe), 32'(1));
    step();
    check("wr_done_dq_oe", 32'(bus.sram_dq_oe), 32'(0));
    wait_drain(50);

    // fill the FIFO while reads keep winning arbitration
    bus.rd_req = 1'b1; bus.rd_addr = rnd_rd_addr();
    bus.wr_valid = 1'b1; bus.wr_addr = rnd_wr_addr(); bus.wr_data = 8'($urandom);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wr_acc) begin
        n_acc++;
        bus.wr_addr = rnd_wr_addr(); bus.wr_data = 8'($urandom);
      end
      if (rd_acc) bus.rd_addr = rnd_rd_addr();
    end
    check("fill_accepted", 32'(n_acc), 32'(4));
    check("fill_wr_ready", 32'(bus.wr_ready), 32'(0));
    bus.wr_valid = 1'b0;
    release_rd();
    wait_drain(100);

    // starvation: one queued write behind a continuous read stream
    bus.rd_req = 1'b1; bus.rd_addr = rnd_rd_addr();
    release_rd();
    bus.rd_req = 1'b1; bus.rd_addr = rnd_rd_addr();
    bus.wr_valid = 1'b1; bus.wr_addr = rnd_wr_addr(); bus.wr_data = 8'($urandom);
    step();
    check("starve_push", 32'(wr_acc), 32'(1));
    bus.wr_valid = 1'b0;
    if (rd_acc) bus.rd_addr = rnd_rd_addr();
    nrd = 0; seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rd_acc) begin
        nrd++;
        bus.rd_addr = rnd_rd_addr();
      end
      if (dq_oe_s) begin
        seen = 1'b1;
        break;
      end
    end
    check("starve_write_seen", 32'(seen), 32'(1));
    check("starve_read_grants", 32'(nrd), 32'(16));
    release_rd();
    wait_drain(100);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (!bus.rd_req && $urandom_range(0, 2) == 0) begin
        bus.rd_req = 1'b1; bus.rd_addr = rnd_rd_addr();
      end
      if (!bus.wr_valid && $urandom_range(0, 3) == 0) begin
        bus.wr_valid = 1'b1; bus.wr_addr = rnd_wr_addr(); bus.wr_data = 8'($urandom);
      end
      step();
      if (rd_acc) bus.rd_req = 1'b0;
      if (wr_acc) bus.wr_valid = 1'b0;
    end
    for (int i = 0; i < 60; i++) begin
      if (!bus.rd_req && !bus.wr_valid) break;
      step();
      if (rd_acc) bus.rd_req = 1'b0;
      if (wr_acc) bus.wr_valid = 1'b0;
    end
    check("random_requests_retired", 32'(bus.rd_req || bus.wr_valid), 32'(0));
    wait_drain(200);

    // reset during the WE pulse, with a second write still queued
    bus.wr_valid = 1'b1; bus.wr_addr = rnd_wr_addr(); bus.wr_data = 8'($urandom);
    step();
    check("rstw_push_a", 32'(wr_acc), 32'(1));
    bus.wr_addr = rnd_wr_addr(); bus.wr_data = 8'($urandom);
    step();
    check("rstw_push_b", 32'(wr_acc), 32'(1));
    bus.wr_valid = 1'b0;
    step();
    check("rstw_in_pulse", 32'(bus.sram_we_n), 32'(0));
    rst = 1'b1;
    wr_q.delete();
    @(posedge clk); #1;
    check("rstw_we_n", 32'(bus.sram_we_n), 32'(1));
    check("rstw_dq_oe", 32'(bus.sram_dq_oe), 32'(0));
    check("rstw_cs_n", 32'(bus.sram_cs_n), 32'(1));
    check("rstw_wr_ready", 32'(bus.wr_ready), 32'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    base = we_falls;
    @(posedge clk); #1;
    check("rstw_cs_n_release", 32'(bus.sram_cs_n), 32'(0));
    repeat (30) step();
    check("rstw_no_writes", 32'(we_falls - base), 32'(0));
    check("rstw_dq_oe_idle", 32'(bus.sram_dq_oe), 32'(0));
    check("rd_q_empty", 32'(rd_q.size()), 32'(0));
    check("wr_q_empty", 32'(wr_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
